seven_seg_scanner: RTL



---
 rtl/seven_seg_pkg.sv | 23 ++
 rtl/seven_seg_scanner_prescaler.sv | 40 ++++
 rtl/seven_seg_scanner.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scanner.
// Optional build macro: SCAN_BLANK_EN (one dark cycle between digits).
package seven_seg_pkg;

    localparam int SEG_W  = 7;
    localparam int DIGITS = 6;

    // Segments are active-low: all ones is a dark digit.
    localparam logic [SEG_W-1:0]  BLANK_SEG  = 7'b1111111;
    localparam logic [DIGITS-1:0] ALL_AN_OFF = 6'b111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_e;

    // Active-low one-hot enable for the given digit.
    function automatic logic [DIGITS-1:0] an_sel(input logic [2:0] idx);
        return ~(DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/seven_seg_scanner_prescaler.sv
// Digit-slot prescaler: counts 0..PRESCALE-1 and flags the last count.
// Clear forces zero, hold freezes the count; neither produces a tick.
module scan_prescaler #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = !clear_i && !hold_i && (cnt_q == LAST);

    // Next count: clear wins, then hold, else wrap on the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (!hold_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Six-digit multiplexed display driver with per-frame input snapshot.
// Optional build macro: SCAN_BLANK_EN (one dark cycle between digits).
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEG_W-1:0] display0,
    input  logic [SEG_W-1:0] display1,
    input  logic [SEG_W-1:0] display2,
    input  logic [SEG_W-1:0] display3,
    input  logic [SEG_W-1:0] display4,
    input  logic [SEG_W-1:0] display5,
    output logic [SEG_W-1:0]  seg_out,
    output logic [DIGITS-1:0] an_out,
    output logic [2:0]        digit_idx,
    output logic              frame_done
);

    localparam logic [2:0] LAST_DIG = 3'(DIGITS - 1);

    state_e            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              fd_q, fd_d;
    logic              load;
    logic              tick;
    logic              pre_clr;
    logic              pre_hold;

    logic [SEG_W-1:0] disp [DIGITS];
    logic [SEG_W-1:0] shadow_q [DIGITS];

    assign disp[0] = display0;
    assign disp[1] = display1;
    assign disp[2] = display2;
    assign disp[3] = display3;
    assign disp[4] = display4;
    assign disp[5] = display5;

    assign pre_clr  = (state_q == IDLE) || !en;
    assign pre_hold = (state_q == BLANK);

    scan_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(pre_clr),
        .hold_i (pre_hold),
        .tick_o (tick)
    );

    // Scan sequencing and next register values for the display outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seg_d   = BLANK_SEG;
        an_d    = ALL_AN_OFF;
        fd_d    = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (en) begin
                    state_d = SCAN;
                    load    = 1'b1;
                end
            end
            SCAN: begin
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    seg_d = shadow_q[idx_q];
                    an_d  = an_sel(idx_q);
                    if (tick) begin
`ifdef SCAN_BLANK_EN
                        state_d = BLANK;
`endif
                        if (idx_q == LAST_DIG) begin
                            idx_d = '0;
                            fd_d  = 1'b1;
                            load  = 1'b1;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    state_d = SCAN;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // FSM, digit index and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            seg_q   <= BLANK_SEG;
            an_q    <= ALL_AN_OFF;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            fd_q    <= fd_d;
        end
    end

    // Frame snapshot of the decoder patterns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                shadow_q[i] <= BLANK_SEG;
            end
        end else if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                shadow_q[i] <= disp[i];
            end
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = fd_q;

endmodule
